// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the controls, and the counter (slave) returns the count and its flags.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] max_val;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             at_limit;
  logic             wrap;
  logic             sat_flag;

  modport master (
    output en, load, load_val, up_dn, sat_mode, max_val, clr_flag,
    input  count, at_limit, wrap, sat_flag
  );

  modport slave (
    input  en, load, load_val, up_dn, sat_mode, max_val, clr_flag,
    output count, at_limit, wrap, sat_flag
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus, a prescaled enable, and wrap/saturate boundaries.
// It outputs a terminal-count flag, a one-cycle wrap pulse and a sticky saturation flag.
module updown_mod_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int               PRESCALE  = 1
) (
  input logic                  clk,
  input logic                  reset,
  updown_mod_counter_if.slave  bus
);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PSW-1:0]   r_pre;
  logic             r_wrap;
  logic             r_sat;

  logic             w_step;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap;
  logic             w_sat;
  logic [WIDTH-1:0] w_load_clamp;

  assign w_step       = bus.en && !bus.load && ((PRESCALE == 1) || (r_pre == PRE_LAST));
  assign w_load_clamp = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;

  // The next count and the boundary events are evaluated for a step at the current edge.
  always_comb begin
    w_nxt  = r_count;
    w_wrap = 1'b0;
    w_sat  = 1'b0;
    if (bus.up_dn) begin
      if (r_count < bus.max_val) begin
        w_nxt = r_count + WIDTH'(1);
      end else if (bus.sat_mode) begin
        w_nxt = bus.max_val;
        w_sat = 1'b1;
      end else begin
        w_nxt  = '0;
        w_wrap = 1'b1;
      end
    end else begin
      // A count left above a lowered max_val snaps down to max_val without raising a flag.
      if (r_count > bus.max_val) begin
        w_nxt = bus.max_val;
      end else if (r_count != '0) begin
        w_nxt = r_count - WIDTH'(1);
      end else if (bus.sat_mode) begin
        w_sat = 1'b1;
      end else begin
        w_nxt  = bus.max_val;
        w_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RESET_VAL;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.load) begin
        r_count <= w_load_clamp;
        r_pre   <= '0;
      end else if (bus.en) begin
        if (w_step) begin
          r_count <= w_nxt;
          r_pre   <= '0;
          r_wrap  <= w_wrap;
        end else begin
          r_pre <= r_pre + PSW'(1);
        end
      end
      if (w_step && w_sat) r_sat <= 1'b1;
      else if (bus.clr_flag) r_sat <= 1'b0;
    end
  end

  assign bus.count    = r_count;
  assign bus.at_limit = (bus.up_dn && (r_count >= bus.max_val)) || (!bus.up_dn && (r_count == '0));
  assign bus.wrap     = r_wrap;
  assign bus.sat_flag = r_sat;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter. It drives a default instance and a PRESCALE=3 instance.
// The driver queues the expected state after each edge, and a monitor compares that state on the falling edge.
module tb_updown_mod_counter;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) b0();
  updown_mod_counter_if #(.WIDTH(4)) b1();

  updown_mod_counter #(.WIDTH(4)) u0 (.clk(clk), .reset(rst0), .bus(b0.slave));
  updown_mod_counter #(.WIDTH(4), .PRESCALE(3)) u1 (.clk(clk), .reset(rst1), .bus(b1.slave));

  typedef struct {
    int         sel;
    string      name;
    logic [3:0] cnt;
    logic       al;
    logic       wr;
    logic       sf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] a_cnt;
  logic       a_al, a_wr, a_sf;

  // Monitor: every expectation queued at a rising edge is compared on the following falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        a_cnt = b0.count; a_al = b0.at_limit; a_wr = b0.wrap; a_sf = b0.sat_flag;
      end else begin
        a_cnt = b1.count; a_al = b1.at_limit; a_wr = b1.wrap; a_sf = b1.sat_flag;
      end
      checks++;
      if (a_cnt !== e.cnt || a_al !== e.al || a_wr !== e.wr || a_sf !== e.sf) begin
        errors++;
        $display("FAIL %s dut%0d: got count=%0d at_limit=%b wrap=%b sat=%b, want count=%0d at_limit=%b wrap=%b sat=%b",
                 e.name, e.sel, a_cnt, a_al, a_wr, a_sf, e.cnt, e.al, e.wr, e.sf);
      end
    end
  end

  task automatic tick(input int sel, input string name, input logic [3:0] c,
                      input logic al, input logic wr, input logic sf);
    exp_t x;
    @(posedge clk);
    x.sel = sel; x.name = name; x.cnt = c; x.al = al; x.wr = wr; x.sf = sf;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.en = 0; b0.load = 0; b0.load_val = 0; b0.up_dn = 0; b0.sat_mode = 0; b0.max_val = 15; b0.clr_flag = 0;
    b1.en = 0; b1.load = 0; b1.load_val = 0; b1.up_dn = 0; b1.sat_mode = 0; b1.max_val = 15; b1.clr_flag = 0;
    #1;
    tick(0, "reset0", 4'd15, 1'b0, 1'b0, 1'b0);
    rst0 = 1'b0;

    // 1: free-running down count with wrap
    b0.en = 1;
    for (int i = 14; i >= 0; i--) tick(0, "t1_down", 4'(i), (i == 0), 1'b0, 1'b0);
    tick(0, "t1_wrap", 4'd15, 1'b0, 1'b1, 1'b0);
    tick(0, "t1_after", 4'd14, 1'b0, 1'b0, 1'b0);

    // 2: up count modulo 10
    b0.en = 0; b0.up_dn = 1; b0.max_val = 9; b0.load = 1; b0.load_val = 7;
    tick(0, "t2_load", 4'd7, 1'b0, 1'b0, 1'b0);
    b0.load = 0; b0.en = 1;
    tick(0, "t2_8", 4'd8, 1'b0, 1'b0, 1'b0);
    tick(0, "t2_9", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(0, "t2_wrap", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(0, "t2_1", 4'd1, 1'b0, 1'b0, 1'b0);

    // 3: saturate down, set beats clear, then clear alone
    b0.en = 0; b0.up_dn = 0; b0.sat_mode = 1; b0.load = 1; b0.load_val = 2;
    tick(0, "t3_load", 4'd2, 1'b0, 1'b0, 1'b0);
    b0.load = 0; b0.en = 1;
    tick(0, "t3_1", 4'd1, 1'b0, 1'b0, 1'b0);
    tick(0, "t3_0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(0, "t3_block", 4'd0, 1'b1, 1'b0, 1'b1);
    b0.clr_flag = 1;
    tick(0, "t3_setwins", 4'd0, 1'b1, 1'b0, 1'b1);
    b0.en = 0;
    tick(0, "t3_clr", 4'd0, 1'b1, 1'b0, 1'b0);
    b0.clr_flag = 0;

    // 5: load clamping, load beats en, lowered max_val
    b0.sat_mode = 0; b0.max_val = 9; b0.load = 1; b0.load_val = 12;
    tick(0, "t5_clamp", 4'd9, 1'b0, 1'b0, 1'b0);
    b0.en = 1; b0.load_val = 8;
    tick(0, "t5_loadwins", 4'd8, 1'b0, 1'b0, 1'b0);
    b0.load = 0; b0.max_val = 5;
    tick(0, "t5_snap", 4'd5, 1'b0, 1'b0, 1'b0);

    // 6: max_val=0 boundary, then reset during load
    b0.max_val = 0;
    tick(0, "t6_snap0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(0, "t6_wrapdn", 4'd0, 1'b1, 1'b1, 1'b0);
    tick(0, "t6_wrapdn2", 4'd0, 1'b1, 1'b1, 1'b0);
    b0.up_dn = 1;
    tick(0, "t6_wrapup", 4'd0, 1'b1, 1'b1, 1'b0);
    b0.sat_mode = 1;
    tick(0, "t6_sat", 4'd0, 1'b1, 1'b0, 1'b1);
    b0.en = 0; b0.clr_flag = 1;
    tick(0, "t6_clr", 4'd0, 1'b1, 1'b0, 1'b0);
    b0.clr_flag = 0; rst0 = 1; b0.load = 1; b0.load_val = 3;
    tick(0, "t6_rstload", 4'd15, 1'b1, 1'b0, 1'b0);
    rst0 = 0; b0.load = 0;

    // 4: prescaler of 3 on the second instance
    tick(1, "reset1", 4'd15, 1'b0, 1'b0, 1'b0);
    rst1 = 0; b1.load = 1; b1.load_val = 10;
    tick(1, "t4_load", 4'd10, 1'b0, 1'b0, 1'b0);
    b1.load = 0; b1.en = 1;
    tick(1, "t4_c1", 4'd10, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c2", 4'd10, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c3", 4'd9, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c4", 4'd9, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c5", 4'd9, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c6", 4'd8, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c7", 4'd8, 1'b0, 1'b0, 1'b0);
    b1.en = 0;
    tick(1, "t4_hold1", 4'd8, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_hold2", 4'd8, 1'b0, 1'b0, 1'b0);
    b1.en = 1;
    tick(1, "t4_c8", 4'd8, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c9", 4'd7, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_c10", 4'd7, 1'b0, 1'b0, 1'b0);
    rst1 = 1;
    tick(1, "t4_rst", 4'd15, 1'b0, 1'b0, 1'b0);
    rst1 = 0;
    tick(1, "t4_r1", 4'd15, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_r2", 4'd15, 1'b0, 1'b0, 1'b0);
    tick(1, "t4_r3", 4'd14, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
